// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares the byte-serial memory controller between IF, LSB and PF with
// round-robin order plus starvation override. `define ARB_PERF_CNT_EN adds grant/abort counters.
module mem_req_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_ls_type,
  input  logic [31:0] lsb_st_val,
  output logic        lsb_done,
  output logic [31:0] lsb_data,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  output logic        pf_done,
  output logic [31:0] pf_data,
  output logic        mc_req_valid,
  output logic        mc_req_wr,
  output logic [31:0] mc_req_addr,
  output logic [2:0]  mc_req_ls_type,
  output logic [31:0] mc_req_st_val,
  output logic        mc_abort,
  input  logic        mc_done,
  input  logic [31:0] mc_ld_val
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_lsb_grants,
  output logic [31:0] perf_pf_grants,
  output logic [31:0] perf_aborts
`endif
);

  localparam logic [2:0]       LS_WORD   = 3'b010;
  localparam logic [1:0]       ID_IF     = 2'd0;
  localparam logic [1:0]       ID_LSB    = 2'd1;
  localparam logic [1:0]       ID_PF     = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t                  state;
  logic [1:0]              rr_ptr;
  logic [1:0]              owner;
  logic [1:0]              winner;
  logic [2:0][CNT_W-1:0]   wait_cnt;
  logic [31:0]             lat_addr;
  logic [31:0]             lat_st_val;
  logic                    lat_wr;
  logic [2:0]              lat_ls_type;
  logic [2:0]              req_vec;
  logic [2:0]              starved;
  logic [2:0]              cnt_clr;
  logic                    grant;
  logic                    busy;
  logic                    abort_now;
  logic                    complete_now;

  // Starved requesters beat the rotating pointer; lowest index wins among them.
  always_comb begin
    req_vec = {pf_req, lsb_req, if_req};
    starved = {pf_req  && (wait_cnt[2] >= CNT_LIMIT),
               lsb_req && (wait_cnt[1] >= CNT_LIMIT),
               if_req  && (wait_cnt[0] >= CNT_LIMIT)};
    winner = ID_IF;
    if (starved[0])      winner = ID_IF;
    else if (starved[1]) winner = ID_LSB;
    else if (starved[2]) winner = ID_PF;
    else begin
      case (rr_ptr)
        ID_IF:   winner = req_vec[0] ? ID_IF  : (req_vec[1] ? ID_LSB : ID_PF);
        ID_LSB:  winner = req_vec[1] ? ID_LSB : (req_vec[2] ? ID_PF  : ID_IF);
        default: winner = req_vec[2] ? ID_PF  : (req_vec[0] ? ID_IF  : ID_LSB);
      endcase
    end
    grant        = (state == IDLE) && rdy && !clr && (|req_vec);
    busy         = (state == BUSY);
    abort_now    = rdy && busy && clr && !lat_wr;
    complete_now = rdy && busy && mc_done && !abort_now;
    cnt_clr[0]   = !if_req  || (grant && winner == ID_IF)  || clr;
    cnt_clr[1]   = !lsb_req || (grant && winner == ID_LSB) || (clr && !lsb_wr);
    cnt_clr[2]   = !pf_req  || (grant && winner == ID_PF)  || clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (rdy) begin
      for (int i = 0; i < 3; i++) begin
        if (cnt_clr[i])                 wait_cnt[i] <= '0;
        else if (wait_cnt[i] != CNT_MAX) wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  // Done/abort/data registers are single-cycle pulses and fall back to zero on every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= ID_IF;
      owner       <= ID_IF;
      lat_addr    <= '0;
      lat_st_val  <= '0;
      lat_wr      <= 1'b0;
      lat_ls_type <= '0;
      if_done     <= 1'b0;
      lsb_done    <= 1'b0;
      pf_done     <= 1'b0;
      if_data     <= '0;
      lsb_data    <= '0;
      pf_data     <= '0;
      mc_abort    <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
      pf_done  <= 1'b0;
      if_data  <= '0;
      lsb_data <= '0;
      pf_data  <= '0;
      mc_abort <= 1'b0;
      if (rdy) begin
        case (state)
          IDLE: begin
            if (grant) begin
              owner       <= winner;
              rr_ptr      <= (winner == ID_PF) ? ID_IF : winner + 2'd1;
              lat_addr    <= (winner == ID_IF) ? if_addr : ((winner == ID_LSB) ? lsb_addr : pf_addr);
              lat_wr      <= (winner == ID_LSB) && lsb_wr;
              lat_ls_type <= (winner == ID_LSB) ? lsb_ls_type : LS_WORD;
              lat_st_val  <= (winner == ID_LSB) ? lsb_st_val : 32'd0;
              state       <= BUSY;
            end
          end
          BUSY: begin
            if (abort_now) begin
              mc_abort <= 1'b1;
              state    <= GAP;
            end else if (complete_now) begin
              case (owner)
                ID_IF: begin
                  if_done <= 1'b1;
                  if_data <= mc_ld_val;
                end
                ID_LSB: begin
                  lsb_done <= 1'b1;
                  lsb_data <= lat_wr ? 32'd0 : mc_ld_val;
                end
                default: begin
                  pf_done <= 1'b1;
                  pf_data <= mc_ld_val;
                end
              endcase
              state <= GAP;
            end
          end
          GAP:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mc_req_valid   = busy;
  assign mc_req_wr      = busy && lat_wr;
  assign mc_req_addr    = busy ? lat_addr : 32'd0;
  assign mc_req_ls_type = busy ? lat_ls_type : 3'd0;
  assign mc_req_st_val  = busy ? lat_st_val : 32'd0;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_grants  <= '0;
      perf_lsb_grants <= '0;
      perf_pf_grants  <= '0;
      perf_aborts     <= '0;
    end else begin
      if (grant && winner == ID_IF)  perf_if_grants  <= perf_if_grants + 32'd1;
      if (grant && winner == ID_LSB) perf_lsb_grants <= perf_lsb_grants + 32'd1;
      if (grant && winner == ID_PF)  perf_pf_grants  <= perf_pf_grants + 32'd1;
      if (abort_now)                 perf_aborts     <= perf_aborts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level reference model of the three-way memory request scheduler.
`timescale 1ns/1ps
module tb_mem_req_arbiter;

  localparam int STARVE_LIMIT = 8;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        if_req, lsb_req, lsb_wr, pf_req, mc_done;
  logic [31:0] if_addr, lsb_addr, lsb_st_val, pf_addr, mc_ld_val;
  logic [2:0]  lsb_ls_type;
  logic        if_done, lsb_done, pf_done, mc_req_valid, mc_req_wr, mc_abort;
  logic [31:0] if_data, lsb_data, pf_data, mc_req_addr, mc_req_st_val;
  logic [2:0]  mc_req_ls_type;
  logic [168:0] all_out;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants, perf_lsb_grants, perf_pf_grants, perf_aborts;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_ls_type(lsb_ls_type),
    .lsb_st_val(lsb_st_val), .lsb_done(lsb_done), .lsb_data(lsb_data),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_done(pf_done), .pf_data(pf_data),
    .mc_req_valid(mc_req_valid), .mc_req_wr(mc_req_wr), .mc_req_addr(mc_req_addr),
    .mc_req_ls_type(mc_req_ls_type), .mc_req_st_val(mc_req_st_val), .mc_abort(mc_abort),
    .mc_done(mc_done), .mc_ld_val(mc_ld_val)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_grants(perf_if_grants), .perf_lsb_grants(perf_lsb_grants),
    .perf_pf_grants(perf_pf_grants), .perf_aborts(perf_aborts)
`endif
  );

  assign all_out = {if_done, if_data, lsb_done, lsb_data, pf_done, pf_data, mc_req_valid,
                    mc_req_wr, mc_req_addr, mc_req_ls_type, mc_req_st_val, mc_abort};

  // Reference model: phase 0 = idle, 1 = transaction in flight, 2 = gap cycle.
  int          m_phase, m_ptr, m_owner;
  int          m_cnt[3];
  logic [31:0] m_addr, m_sv;
  logic        m_wr;
  logic [2:0]  m_lt;
  bit          m_done[3];
  logic [31:0] m_data[3];
  bit          m_abort;

  function automatic void model_reset();
    m_phase = 0; m_ptr = 0; m_owner = 0;
    m_addr = 0; m_sv = 0; m_wr = 0; m_lt = 0; m_abort = 0;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_done[i] = 0; m_data[i] = 0;
    end
  endfunction

  function automatic void model_step();
    bit req[3];
    int win;
    req[0] = if_req; req[1] = lsb_req; req[2] = pf_req;
    win = -1;
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 0; m_data[i] = 0;
    end
    m_abort = 0;
    if (!rdy) return;
    if (m_phase == 0 && !clr && (req[0] || req[1] || req[2])) begin
      for (int i = 0; i < 3; i++)
        if (win < 0 && req[i] && m_cnt[i] >= STARVE_LIMIT) win = i;
      for (int k = 0; k < 3; k++)
        if (win < 0 && req[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
    end
    for (int i = 0; i < 3; i++) begin
      if (i == win || !req[i] || (clr && !(i == 1 && lsb_wr))) m_cnt[i] = 0;
      else if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
    end
    case (m_phase)
      0: if (win >= 0) begin
        m_owner = win;
        m_ptr   = (win + 1) % 3;
        m_wr    = (win == 1) && lsb_wr;
        m_addr  = (win == 0) ? if_addr : ((win == 1) ? lsb_addr : pf_addr);
        m_lt    = (win == 1) ? lsb_ls_type : 3'b010;
        m_sv    = (win == 1) ? lsb_st_val : 32'd0;
        m_phase = 1;
      end
      1: if (clr && !m_wr) begin
        m_abort = 1;
        m_phase = 2;
      end else if (mc_done) begin
        m_done[m_owner] = 1;
        m_data[m_owner] = m_wr ? 32'd0 : mc_ld_val;
        m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; rdy = 1; clr = 0; mc_done = 0; mc_ld_val = 0;
    if_req = 0; lsb_req = 0; pf_req = 0; lsb_wr = 0;
    if_addr = 0; lsb_addr = 0; pf_addr = 0; lsb_st_val = 0; lsb_ls_type = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; rdy = 1; clr = 0; mc_done = 0; mc_ld_val = 32'h1111_2222;
    if_req = 1; lsb_req = 1; pf_req = 1; lsb_wr = 1;
    if_addr = 32'h10; lsb_addr = 32'h20; pf_addr = 32'h30; lsb_st_val = 32'h55; lsb_ls_type = 3'b001;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h want 0", all_out);
    end
    if_req = 0; lsb_req = 0; pf_req = 0; lsb_wr = 0;
    rst = 0;
    tick(); tick();
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++;
      $display("[TB] FAIL idle_no_request: got %h want 0", all_out);
    end
  endtask

  task automatic test_if_only();
    do_reset();
    if_req = 1; if_addr = 32'h1000;
    tick();
    tests_run++;
    if ({mc_req_valid, mc_req_wr, mc_req_addr, mc_req_ls_type} !== {1'b1, 1'b0, 32'h1000, 3'b010}) begin
      tests_failed++;
      $display("[TB] FAIL if_only_req: got %b/%b/%h/%b want 1/0/1000/010",
               mc_req_valid, mc_req_wr, mc_req_addr, mc_req_ls_type);
    end
    tick(); tick(); tick();
    mc_done = 1; mc_ld_val = 32'hDEAD_BEEF;
    tick();
    mc_done = 0;
    tests_run++;
    if ({if_done, lsb_done, pf_done, mc_abort, if_data, mc_req_valid} !== {4'b1000, 32'hDEAD_BEEF, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL if_only_done: got dones=%b data=%h valid=%b want 1000/deadbeef/0",
               {if_done, lsb_done, pf_done, mc_abort}, if_data, mc_req_valid);
    end
    if_req = 0;
    tick();
    tests_run++;
    if ({if_done, mc_req_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL if_only_gap: got done=%b valid=%b want 0/0", if_done, mc_req_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] addrs[3];
    logic [31:0] got_data;
    int          id;
    addrs[0] = 32'h100; addrs[1] = 32'h200; addrs[2] = 32'h300;
    do_reset();
    if_addr = addrs[0]; lsb_addr = addrs[1]; pf_addr = addrs[2];
    lsb_wr = 0; lsb_ls_type = 3'b100;
    if_req = 1; lsb_req = 1; pf_req = 1;
    for (int g = 0; g < 6; g++) begin
      id = g % 3;
      tick();
      tests_run++;
      if ({mc_req_valid, mc_req_addr} !== {1'b1, addrs[id]}) begin
        tests_failed++;
        $display("[TB] FAIL rr_grant %0d: got valid=%b addr=%h want 1/%h", g, mc_req_valid, mc_req_addr, addrs[id]);
      end
      tick();
      mc_done = 1; mc_ld_val = 32'hA000_0000 + 32'(g);
      tick();
      mc_done = 0;
      got_data = (id == 0) ? if_data : ((id == 1) ? lsb_data : pf_data);
      tests_run++;
      if ({if_done, lsb_done, pf_done} !== (3'b100 >> id) || got_data !== 32'hA000_0000 + 32'(g)) begin
        tests_failed++;
        $display("[TB] FAIL rr_done %0d: got dones=%b data=%h want %b/%h", g,
                 {if_done, lsb_done, pf_done}, got_data, 3'b100 >> id, 32'hA000_0000 + 32'(g));
      end
      tick();
    end
    if_req = 0; lsb_req = 0; pf_req = 0;
  endtask

  task automatic test_starvation();
    do_reset();
    if_addr = 32'h1100; lsb_addr = 32'h2200; pf_addr = 32'h3300; lsb_wr = 0; lsb_ls_type = 3'b010;
    if_req = 1; pf_req = 1;
    tick();
    repeat (9) tick();
    mc_done = 1; mc_ld_val = 32'h0000_00AA;
    tick();
    mc_done = 0;
    if_req = 0; lsb_req = 1;
    tick();
    if_req = 1; if_addr = 32'h1104;
    tick();
    tests_run++;
    if ({mc_req_valid, mc_req_addr} !== {1'b1, 32'h3300}) begin
      tests_failed++;
      $display("[TB] FAIL starve_pf_wins: got valid=%b addr=%h want 1/3300", mc_req_valid, mc_req_addr);
    end
    mc_done = 1; mc_ld_val = 32'h5A5A_0001;
    tick();
    mc_done = 0;
    tests_run++;
    if ({pf_done, pf_data} !== {1'b1, 32'h5A5A_0001}) begin
      tests_failed++;
      $display("[TB] FAIL starve_pf_done: got %b/%h want 1/5a5a0001", pf_done, pf_data);
    end
    pf_req = 0;
    tick(); tick();
    tests_run++;
    if ({mc_req_valid, mc_req_addr} !== {1'b1, 32'h1104}) begin
      tests_failed++;
      $display("[TB] FAIL starve_rr_resume: got valid=%b addr=%h want 1/1104", mc_req_valid, mc_req_addr);
    end
    if_req = 0; lsb_req = 0;
  endtask

  task automatic test_clr();
    do_reset();
    if_req = 1; if_addr = 32'h4000;
    tick(); tick();
    clr = 1;
    tick();
    tests_run++;
    if ({mc_abort, if_done, mc_req_valid} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL clr_if_abort: got abort/done/valid=%b want 100", {mc_abort, if_done, mc_req_valid});
    end
    clr = 0; if_req = 0;
    tick();
    tests_run++;
    if ({mc_abort, if_done} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL clr_abort_width: got abort/done=%b want 00", {mc_abort, if_done});
    end
    if_req = 1; if_addr = 32'h4004;
    lsb_req = 1; lsb_wr = 1; lsb_addr = 32'h30000; lsb_st_val = 32'h1234_5678; lsb_ls_type = 3'b001;
    tick();
    tests_run++;
    if ({mc_req_valid, mc_req_wr, mc_req_addr, mc_req_ls_type, mc_req_st_val} !==
        {1'b1, 1'b1, 32'h30000, 3'b001, 32'h1234_5678}) begin
      tests_failed++;
      $display("[TB] FAIL clr_ptr_store_req: got %b/%b/%h/%b/%h want 1/1/30000/001/12345678",
               mc_req_valid, mc_req_wr, mc_req_addr, mc_req_ls_type, mc_req_st_val);
    end
    clr = 1;
    tick();
    clr = 0;
    tests_run++;
    if ({mc_abort, mc_req_valid} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL clr_store_ignored: got abort/valid=%b want 01", {mc_abort, mc_req_valid});
    end
    mc_done = 1; mc_ld_val = 32'hFFFF_FFFF;
    tick();
    mc_done = 0;
    tests_run++;
    if ({lsb_done, lsb_data, mc_abort} !== {1'b1, 32'd0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL clr_store_done: got %b/%h/%b want 1/00000000/0", lsb_done, lsb_data, mc_abort);
    end
    lsb_req = 0; if_req = 0; lsb_wr = 0;
  endtask

  task automatic test_done_clr_same();
    do_reset();
    pf_req = 1; pf_addr = 32'h5000;
    tick();
    mc_done = 1; clr = 1; mc_ld_val = 32'hCAFE_F00D;
    tick();
    mc_done = 0; clr = 0; pf_req = 0;
    tests_run++;
    if ({mc_abort, pf_done, pf_data} !== {1'b1, 1'b0, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL done_clr_abort_wins: got %b/%b/%h want 1/0/0", mc_abort, pf_done, pf_data);
    end
    tick();
    tests_run++;
    if ({mc_abort, pf_done} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL done_clr_after: got abort/done=%b want 00", {mc_abort, pf_done});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    lsb_req = 1; lsb_wr = 0; lsb_addr = 32'h6000; lsb_ls_type = 3'b000;
    tick();
    #2 rst = 1;
    #1;
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got %h want 0", all_out);
    end
    model_reset();
    lsb_req = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_rdy_hold();
    do_reset();
    if_req = 1; if_addr = 32'h7000;
    tick();
    rdy = 0; mc_done = 1; mc_ld_val = 32'h0BAD_F00D;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if ({mc_req_valid, mc_req_addr, if_done, mc_abort} !== {1'b1, 32'h7000, 2'b00}) begin
        tests_failed++;
        $display("[TB] FAIL rdy_hold %0d: got valid=%b addr=%h done=%b abort=%b want 1/7000/0/0",
                 c, mc_req_valid, mc_req_addr, if_done, mc_abort);
      end
    end
    rdy = 1;
    tick();
    mc_done = 0; if_req = 0;
    tests_run++;
    if ({if_done, if_data} !== {1'b1, 32'h0BAD_F00D}) begin
      tests_failed++;
      $display("[TB] FAIL rdy_resume_done: got %b/%h want 1/0badf00d", if_done, if_data);
    end
  endtask

  task automatic test_random();
    logic [68:0] exp_req, got_req;
    logic [3:0]  exp_pulse, got_pulse;
    logic [95:0] exp_data, got_data;
    do_reset();
    for (int c = 0; c < 900; c++) begin
      rdy       = ($urandom_range(0, 9) != 0);
      clr       = ($urandom_range(0, 19) == 0);
      mc_done   = (m_phase == 1) && ($urandom_range(0, (c < 450) ? 2 : 11) == 0);
      mc_ld_val = $urandom();
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = $urandom();
      end
      if (!lsb_req && $urandom_range(0, 3) == 0) begin
        lsb_req = 1; lsb_wr = 1'($urandom_range(0, 1)); lsb_addr = $urandom();
        lsb_st_val = $urandom(); lsb_ls_type = 3'($urandom_range(0, 7));
      end
      if (!pf_req && $urandom_range(0, 3) == 0) begin
        pf_req = 1; pf_addr = $urandom();
      end
      if ($urandom_range(0, 59) == 0) pf_req = 0;
      tick();
      exp_req   = (m_phase == 1) ? {1'b1, m_wr, m_addr, m_lt, m_sv} : 69'd0;
      got_req   = {mc_req_valid, mc_req_wr, mc_req_addr, mc_req_ls_type, mc_req_st_val};
      exp_pulse = {m_done[0], m_done[1], m_done[2], m_abort};
      got_pulse = {if_done, lsb_done, pf_done, mc_abort};
      exp_data  = {m_data[0], m_data[1], m_data[2]};
      got_data  = {if_data, lsb_data, pf_data};
      tests_run++;
      if (got_req !== exp_req) begin
        tests_failed++;
        $display("[TB] FAIL rand_req cycle %0d: got %h want %h", c, got_req, exp_req);
      end
      tests_run++;
      if (got_pulse !== exp_pulse) begin
        tests_failed++;
        $display("[TB] FAIL rand_pulse cycle %0d: got %b want %b", c, got_pulse, exp_pulse);
      end
      tests_run++;
      if (got_data !== exp_data) begin
        tests_failed++;
        $display("[TB] FAIL rand_data cycle %0d: got %h want %h", c, got_data, exp_data);
      end
      if (m_done[0] || (m_abort && m_owner == 0)) if_req = 0;
      if (m_done[1] || (m_abort && m_owner == 1)) lsb_req = 0;
      if (m_done[2] || (m_abort && m_owner == 2)) pf_req = 0;
    end
    if_req = 0; lsb_req = 0; pf_req = 0; clr = 0; mc_done = 0; rdy = 1;
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_round_robin();
    test_starvation();
    test_clr();
    test_done_clr_same();
    test_async_reset();
    test_rdy_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
